sync_fifo_flex: RTL

Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO. Adds configurable almost-full/almost-empty thresholds, an occupancy count, a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and separate overflow/underflow reporting with a sticky error. It sits between a producer and a consumer in the same clock domain and is driven by the existing interface-based UVM-lite bench.

---
 rtl/sync_fifo_flex_pkg.sv | 16 +
 rtl/sync_fifo_flex_if.sv | 40 ++++
 rtl/sync_fifo_flex_mem.sv | 24 ++
 rtl/sync_fifo_flex.sv | 107 ++++++++++
 4 files changed

// File: rtl/sync_fifo_flex_pkg.sv
// Shared defaults and helpers for the flexible synchronous FIFO.
// Read-mode encodings and count-width helper live here.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Count must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex.
// master drives requests, slave is the FIFO itself.
interface sync_fifo_flex_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = cnt_width(DEPTH);

    logic             clear_i;
    logic             wr_en_i;
    logic [WIDTH-1:0] wdata_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             rvalid_o;
    logic             empty_o;
    logic             full_o;
    logic             almost_empty_o;
    logic             almost_full_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;
    logic             underflow_o;
    logic             error_o;

    modport master (
        output clear_i, wr_en_i, wdata_i, rd_en_i,
        input  rdata_o, rvalid_o, empty_o, full_o,
        input  almost_empty_o, almost_full_o, count_o,
        input  overflow_o, underflow_o, error_o
    );

    modport slave (
        input  clear_i, wr_en_i, wdata_i, rd_en_i,
        output rdata_o, rvalid_o, empty_o, full_o,
        output almost_empty_o, almost_full_o, count_o,
        output overflow_o, underflow_o, error_o
    );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// FIFO storage: synchronous write, asynchronous read.
// Storage is deliberately not reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with thresholds, count, FWFT option,
// synchronous flush and sticky overflow/underflow error.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = MODE_STD
) (
    input logic             clk_i,
    input logic             rst_i,
    sync_fifo_flex_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);

    logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [WIDTH-1:0]         mem_rdata, rdata_q;
    logic                     ovf_q, unf_q, err_q, rvalid_q;
    logic                     empty, full;
    logic                     rd_acc, wr_acc, ovf_d, unf_d;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [ADDRESS_WIDTH-1:0] bump(
        input logic [ADDRESS_WIDTH-1:0] p
    );
        return (p == LAST) ? '0 : p + ADDRESS_WIDTH'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign rd_acc = bus.rd_en_i && !empty && !bus.clear_i;
    assign wr_acc = bus.wr_en_i && (!full || rd_acc) && !bus.clear_i;
    assign ovf_d  = bus.wr_en_i && !wr_acc && !bus.clear_i;
    assign unf_d  = bus.rd_en_i && !rd_acc && !bus.clear_i;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDRESS_WIDTH)
    ) u_mem (
        .clk   (clk_i),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.wdata_i),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (bus.clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= bump(wr_ptr);
            if (rd_acc) rd_ptr <= bump(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            err_q    <= err_q | ovf_d | unf_d;
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem_rdata;
        end
    end

    // FWFT presents the head word directly; zero while empty.
    assign bus.rdata_o = (FWFT == MODE_FWFT)
                       ? (empty ? '0 : mem_rdata)
                       : rdata_q;
    assign bus.rvalid_o = (FWFT == MODE_FWFT) ? !empty : rvalid_q;

    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_empty_o = (count <= AE_C);
    assign bus.almost_full_o  = (count >= AF_C);
    assign bus.count_o        = count;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
    assign bus.error_o        = err_q;

endmodule
